aes_ahb_master: RTL
===================

# aes_ahb_master

AHB-Lite initiator that drives the 128-bit AES accelerator slave across its bus interface. A host-side command port starts one block operation. The block then issues the bus sequence: key write to address 0 (skippable), data write to address 32, fixed processing wait, and result read from address 32. It returns the result, or flags a bus error or timeout, and sits between the system controller and the accelerator's AHB slave port.

## Interface
- ADDR_KEY, 16'd0, key write address
- ADDR_DATA, 16'd32, plaintext write address
- ADDR_RESULT, 16'd32, result read address
- PROC_CYCLES, 12, idle cycles between data write completion and result read (0–255; 0 = no wait)
- TIMEOUT, 64, maximum consecutive HREADY-low cycles in one data phase (1–255)

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  command strobe; sampled only in IDLE
- load_key  in  1  1 = write key this command; 0 = reuse the stored key if one exists
- key_in  in  128  key, latched on an accepted start
- data_in  in  128  plaintext, latched on an accepted start
- busy  out  1  high from the cycle after an accepted start through DONE/ERR
- done  out  1  one-cycle pulse; result is valid
- error  out  1  sticky; cleared by the next accepted start
- result  out  128  last read HRDATA; held until the next successful read
- HADDR  out  16  bus address
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ only
- HWRITE  out  1  transfer direction
- HWDATA  out  128  write data
- HRDATA  in  128  read data
- HREADY  in  1  slave HREADYOUT
- HRESP  in  1  slave error response

## Operation
- Register reset values: HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, result=0, key_loaded=0, state=IDLE.
- States: IDLE, KEY_A, KEY_D, DAT_A, DAT_D, WAIT, RD_A, RD_D, DONE, ERR.
- IDLE + start:
  - Latch key_in and data_in; clear error.
  - Go to KEY_A if load_key=1 or key_loaded=0; otherwise go to DAT_A.
- Address states (KEY_A, DAT_A, RD_A):
  - Drive HTRANS=10 with the matching HADDR and HWRITE (1, 1, 0).
  - Hold while HREADY=0; advance to the matching data state on an edge with HREADY=1.
- Data states (KEY_D, DAT_D, RD_D):
  - Drive HTRANS=00.
  - HWDATA carries the latched key or data, and is held for the whole data phase.
  - HADDR and HWRITE hold their address-phase values.
  - Completion: an edge with HREADY=1 and HRESP=0.
  - KEY_D completion: set key_loaded and go to DAT_A.
  - DAT_D completion: go to WAIT, loading the counter with PROC_CYCLES.
  - RD_D completion: capture HRDATA into result and go to DONE.
- WAIT: decrement each cycle; go to RD_A when the count is 0 (PROC_CYCLES=0 passes through WAIT in 1 cycle).
- Error conditions:
  - HRESP=1 sampled in any data state, or TIMEOUT consecutive HREADY=0 cycles in one data phase, goes to ERR.
  - HRESP in an address state is ignored.
  - A key-phase error clears key_loaded.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 (sticky), HTRANS=00, then IDLE next cycle.
- busy is high in every state except IDLE.
- Overlapped/pipelined transfers are never issued. HTRANS=10 appears only in address states.

## Timing
- Zero-wait-state latency from the start edge to the done pulse:
  - load_key=1: 8+PROC_CYCLES cycles (KEY_A, KEY_D, DAT_A, DAT_D, WAIT×(PROC_CYCLES+1), RD_A, RD_D, DONE).
  - key reuse: 6+PROC_CYCLES cycles.
- Each HREADY-low cycle adds one cycle to the phase it occurs in.
- The timeout counter resets on entry to each data state. ERR is entered on the edge where the count reaches TIMEOUT.
- start asserted while busy=1 is ignored. A start in the DONE or ERR cycle is also ignored, since start is sampled only in IDLE.
- rst mid-operation: on the next edge return to reset values, including key_loaded=0 and HTRANS=00. Any outstanding bus transfer is abandoned.
- result and error update only on the edge entering DONE (result) or ERR (error).

## Test plan
- Reset, then start with load_key=1, key=09CF4F3C_ABF71588_28AED2A6_2B7E1516, data=AAF43DDD_A22100EF_8766450A_B4321176, slave zero-wait, PROC_CYCLES=12, slave echoes data:
  - Key NONSEQ write at HADDR 0, then data write at HADDR 32, then read at HADDR 32.
  - done occurs 20 cycles after start; result=data.
- Second start with load_key=0 -> no transfer to HADDR 0; done 18 cycles after start.
- Slave holds HREADY=0 for 3 cycles in DAT_D -> HWDATA stable throughout; done delayed exactly 3 cycles.
- HRESP=1 during KEY_D -> error=1, done never pulses, HTRANS=00, busy falls. A following load_key=0 start still writes the key (key_loaded was cleared).
- HREADY held low in RD_D for TIMEOUT=64 cycles -> ERR, error=1, result unchanged. Pulsing start during busy has no effect.
- Assert rst during WAIT -> next cycle all outputs at reset values. A later load_key=0 start issues a key write.

Source files
------------

// File: rtl/aes_ahb_master_if.sv
// AHB-Lite signal bundle between the AES initiator and the accelerator's
// slave port. The master drives address/control/write data; the slave
// returns read data, HREADYOUT (seen here as HREADY) and the error response.
//   HADDR  [15:0]  bus address
//   HTRANS [1:0]   2'b00 IDLE or 2'b10 NONSEQ
//   HWRITE         1 = write transfer
//   HWDATA [127:0] write data (valid in the data phase)
//   HRDATA [127:0] read data
//   HREADY         data phase completes when high
//   HRESP          1 = slave error response
interface aes_ahb_master_if;
    logic [15:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [127:0] HWDATA;
    logic [127:0] HRDATA;
    logic         HREADY;
    logic         HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator for the 128-bit AES accelerator. One host command runs
// an optional key write, a plaintext write, a fixed processing wait and a
// result read, then pulses done or raises a sticky error.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, load_key     command strobe (sampled in IDLE) and key-write request
//   key_in, data_in     128-bit key / plaintext, latched on an accepted start
//   busy, done, error   status: busy outside IDLE, one-cycle done, sticky error
//   result              last successfully read HRDATA
//   ahb                 AHB-Lite master bundle
// All outputs are registers loaded from the next-state decode, so they line
// up exactly with the state the machine is in.
module aes_ahb_master #(
    parameter logic [15:0] ADDR_KEY    = 16'd0,
    parameter logic [15:0] ADDR_DATA   = 16'd32,
    parameter logic [15:0] ADDR_RESULT = 16'd32,
    parameter int unsigned PROC_CYCLES = 12,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_key,
    input  logic [127:0]          key_in,
    input  logic [127:0]          data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [127:0]          result,
    aes_ahb_master_if.master      ahb
);

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_A, S_KEY_D, S_DAT_A, S_DAT_D,
        S_WAIT, S_RD_A, S_RD_D, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(PROC_CYCLES);
    // Last stalled count before the timeout fires on the following low edge.
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic           key_loaded_q, key_loaded_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic [7:0]     to_cnt_q, to_cnt_d;
    logic [15:0]    haddr_q, haddr_d;
    logic [1:0]     htrans_q, htrans_d;
    logic           hwrite_q, hwrite_d;
    logic [127:0]   hwdata_q, hwdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [127:0]   result_q, result_d;

    // Shared data-phase handling: HRESP wins, then completion, then the
    // consecutive-stall counter.
    function automatic logic stall_timeout(input logic [7:0] cnt);
        return cnt == TO_LAST;
    endfunction

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        data_d       = data_q;
        key_loaded_d = key_loaded_q;
        wait_cnt_d   = wait_cnt_q;
        to_cnt_d     = to_cnt_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hwdata_d     = hwdata_q;
        error_d      = error_q;
        result_d     = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    data_d  = data_in;
                    error_d = 1'b0;
                    state_d = (load_key || !key_loaded_q) ? S_KEY_A : S_DAT_A;
                end
            end
            S_KEY_A: begin
                if (ahb.HREADY) begin
                    state_d  = S_KEY_D;
                    to_cnt_d = 8'd0;
                    hwdata_d = key_q;
                end
            end
            S_DAT_A: begin
                if (ahb.HREADY) begin
                    state_d  = S_DAT_D;
                    to_cnt_d = 8'd0;
                    hwdata_d = data_q;
                end
            end
            S_RD_A: begin
                if (ahb.HREADY) begin
                    state_d  = S_RD_D;
                    to_cnt_d = 8'd0;
                end
            end
            S_KEY_D, S_DAT_D, S_RD_D: begin
                if (ahb.HRESP) begin
                    state_d = S_ERR;
                end else if (ahb.HREADY) begin
                    if (state_q == S_KEY_D) begin
                        key_loaded_d = 1'b1;
                        state_d      = S_DAT_A;
                    end else if (state_q == S_DAT_D) begin
                        wait_cnt_d = WAIT_LOAD;
                        state_d    = S_WAIT;
                    end else begin
                        result_d = ahb.HRDATA;
                        state_d  = S_DONE;
                    end
                end else if (stall_timeout(to_cnt_q)) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
                // A failed key phase leaves the slave's key unknown.
                if (state_q == S_KEY_D && state_d == S_ERR) begin
                    key_loaded_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    state_d = S_RD_A;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) begin
            error_d = 1'b1;
        end

        // Address/control change only when an address phase is presented
        // and hold through the following data phase.
        htrans_d = 2'b00;
        case (state_d)
            S_KEY_A: begin haddr_d = ADDR_KEY;    hwrite_d = 1'b1; htrans_d = 2'b10; end
            S_DAT_A: begin haddr_d = ADDR_DATA;   hwrite_d = 1'b1; htrans_d = 2'b10; end
            S_RD_A:  begin haddr_d = ADDR_RESULT; hwrite_d = 1'b0; htrans_d = 2'b10; end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            data_q       <= '0;
            key_loaded_q <= 1'b0;
            wait_cnt_q   <= '0;
            to_cnt_q     <= '0;
            haddr_q      <= '0;
            htrans_q     <= 2'b00;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            data_q       <= data_d;
            key_loaded_q <= key_loaded_d;
            wait_cnt_q   <= wait_cnt_d;
            to_cnt_q     <= to_cnt_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hwdata_q     <= hwdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            result_q     <= result_d;
        end
    end

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HWDATA = hwdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign result     = result_q;

endmodule
